// File: rtl/mor1kx_branch_predictor_saturation_pkg.sv
// Shared definitions for the saturating-counter branch predictor.
// Index LSB offset (word-aligned PCs) and the counter update direction.
package mor1kx_branch_predictor_saturation_pkg;

  localparam int BP_IDX_LSB = 2;

  typedef enum logic {
    CTR_DEC = 1'b0,
    CTR_INC = 1'b1
  } ctr_dir_e;

endpackage

// File: rtl/mor1kx_branch_predictor_saturation_sat_counter.sv
// Next-state function of one CW-bit up/down saturating counter.
// Pure combinational; sits on the table write path.
module mor1kx_branch_predictor_saturation_sat_counter
  import mor1kx_branch_predictor_saturation_pkg::*;
#(
  parameter int COUNTER_WIDTH = 2
) (
  input  logic [COUNTER_WIDTH-1:0] cnt,
  input  ctr_dir_e                 dir,
  output logic [COUNTER_WIDTH-1:0] cnt_next
);

  localparam logic [COUNTER_WIDTH-1:0] CTR_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    cnt_next = cnt;
    if (dir == CTR_INC) begin
      if (cnt != '1) cnt_next = cnt + CTR_ONE;
    end else begin
      if (cnt != '0) cnt_next = cnt - CTR_ONE;
    end
  end

endmodule

// File: rtl/mor1kx_branch_predictor_saturation.sv
// Dynamic l.bf/l.bnf predictor: PC-indexed table of saturating counters.
// Define MOR1KX_BP_GSHARE_EN to XOR a global taken-history into the index.
module mor1kx_branch_predictor_saturation
  import mor1kx_branch_predictor_saturation_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TABLE_INDEX_WIDTH    = 6,
  parameter int COUNTER_WIDTH        = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            padv_execute_i,
  input  logic                            pipeline_flush_i,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
  output logic                            predicted_flag_o,
  input  logic                            execute_op_bf_i,
  input  logic                            execute_op_bnf_i,
  input  logic                            flag_i,
  output logic                            branch_mispredict_o
);

  localparam int TABLE_SIZE = 2 ** TABLE_INDEX_WIDTH;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [COUNTER_WIDTH-1:0] CTR_RESET = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};

  logic [COUNTER_WIDTH-1:0]     ctr_table [TABLE_SIZE];
  logic [COUNTER_WIDTH-1:0]     ctr_next;
  logic [TABLE_INDEX_WIDTH-1:0] pc_idx;
  logic [TABLE_INDEX_WIDTH-1:0] decode_idx;
  logic [TABLE_INDEX_WIDTH-1:0] exec_idx_r;
  logic                         exec_pred_r;
  logic                         exec_valid_r;
  logic                         taken_pred;
  logic                         decode_branch;
  logic                         execute_branch;
  logic                         actual_taken;
  logic                         upd;
  logic                         unused_pc;

  assign pc_idx    = decode_pc_i[TABLE_INDEX_WIDTH+BP_IDX_LSB-1:BP_IDX_LSB];
  assign unused_pc = ^{decode_pc_i[OPTION_OPERAND_WIDTH-1:TABLE_INDEX_WIDTH+BP_IDX_LSB],
                       decode_pc_i[BP_IDX_LSB-1:0]};

`ifdef MOR1KX_BP_GSHARE_EN
  logic [TABLE_INDEX_WIDTH-1:0] ghr;

  assign decode_idx = pc_idx ^ ghr;

  // History advances only on a real resolution; flushes leave it alone.
  always_ff @(posedge clk) begin
    if (rst) ghr <= '0;
    else if (upd) ghr <= {ghr[TABLE_INDEX_WIDTH-2:0], actual_taken};
  end
`else
  assign decode_idx = pc_idx;
`endif

  assign decode_branch  = op_bf_i | op_bnf_i;
  assign execute_branch = execute_op_bf_i | execute_op_bnf_i;

  assign taken_pred       = ctr_table[decode_idx][COUNTER_WIDTH-1];
  assign predicted_flag_o = op_bf_i ? taken_pred : (op_bnf_i ? ~taken_pred : 1'b0);

  assign actual_taken = (execute_op_bf_i & flag_i) | (execute_op_bnf_i & ~flag_i);
  assign upd          = padv_execute_i & exec_valid_r & execute_branch;

  assign branch_mispredict_o = exec_valid_r & execute_branch & (exec_pred_r != flag_i);

  mor1kx_branch_predictor_saturation_sat_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_sat_counter (
    .cnt      (ctr_table[exec_idx_r]),
    .dir      (actual_taken ? CTR_INC : CTR_DEC),
    .cnt_next (ctr_next)
  );

  // Decode reads the registered table, so a same-cycle write is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TABLE_SIZE; i++) ctr_table[i] <= CTR_RESET;
    end else if (upd) begin
      ctr_table[exec_idx_r] <= ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_valid_r <= 1'b0;
      exec_pred_r  <= 1'b0;
      exec_idx_r   <= '0;
    end else if (pipeline_flush_i) begin
      exec_valid_r <= 1'b0;
    end else if (padv_decode_i) begin
      exec_valid_r <= decode_branch;
      if (decode_branch) begin
        exec_idx_r  <= decode_idx;
        exec_pred_r <= predicted_flag_o;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_branch_predictor_saturation.sv
// Self-checking bench for mor1kx_branch_predictor_saturation (default parameters).
// A behavioural model plus an execute-stage scoreboard queue supplies all expectations.
module tb_mor1kx_branch_predictor_saturation;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv_decode, padv_execute, pipeline_flush;
  logic        op_bf, op_bnf;
  logic [31:0] decode_pc;
  logic        predicted_flag;
  logic        execute_op_bf, execute_op_bnf, flag;
  logic        branch_mispredict;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    bit pred;
  } sb_entry_t;

  typedef struct {
    logic [31:0] pc;
    bit bf, bnf, ebf, ebnf, f;
    bit exp_pred, exp_misp;
  } vec_t;

  sb_entry_t sb_q[$];
  int        m_ctr[64];
  bit [5:0]  m_ghr;
  vec_t      vecs[8];

  always #5 clk = ~clk;

  mor1kx_branch_predictor_saturation dut (
    .clk                 (clk),
    .rst                 (rst),
    .padv_decode_i       (padv_decode),
    .padv_execute_i      (padv_execute),
    .pipeline_flush_i    (pipeline_flush),
    .op_bf_i             (op_bf),
    .op_bnf_i            (op_bnf),
    .decode_pc_i         (decode_pc),
    .predicted_flag_o    (predicted_flag),
    .execute_op_bf_i     (execute_op_bf),
    .execute_op_bnf_i    (execute_op_bnf),
    .flag_i              (flag),
    .branch_mispredict_o (branch_mispredict)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
`ifdef MOR1KX_BP_GSHARE_EN
    return int'(pc[7:2] ^ m_ghr);
`else
    return int'(pc[7:2]);
`endif
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_ghr = '0;
    sb_q.delete();
  endtask

  // One clock: drive at posedge+1, check mid-cycle, advance model at the edge.
  task automatic cyc(input bit r, input bit pd, input bit pe, input bit fl,
                     input bit bf, input bit bnf, input logic [31:0] pc,
                     input bit ebf, input bit ebnf, input bit f);
    int i, j;
    bit tp, ep, ev, em, act;
    rst = r; padv_decode = pd; padv_execute = pe; pipeline_flush = fl;
    op_bf = bf; op_bnf = bnf; decode_pc = pc;
    execute_op_bf = ebf; execute_op_bnf = ebnf; flag = f;
    #4;
    i  = m_index(pc);
    tp = (m_ctr[i] >= 2);
    ep = bf ? tp : (bnf ? !tp : 1'b0);
    ev = (sb_q.size() != 0);
    em = 1'b0;
    if (ev) em = (ebf || ebnf) && (sb_q[0].pred != f);
    check("predicted_flag", predicted_flag, ep);
    check("branch_mispredict", branch_mispredict, em);
    if (r) begin
      reset_model();
    end else begin
      if (pe && ev && (ebf || ebnf)) begin
        act = (ebf && f) || (ebnf && !f);
        j = sb_q[0].idx;
        if (act) begin
          if (m_ctr[j] < 3) m_ctr[j]++;
        end else begin
          if (m_ctr[j] > 0) m_ctr[j]--;
        end
        m_ghr = {m_ghr[4:0], act};
      end
      if (fl) sb_q.delete();
      else if (pd) begin
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        if (bf || bnf) sb_q.push_back('{i, ep});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pcs[6];
    pcs[0] = 32'h100; pcs[1] = 32'h114; pcs[2] = 32'h214;
    pcs[3] = 32'h200; pcs[4] = 32'h300; pcs[5] = 32'h014;

    vecs[0] = '{32'h100, 1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{32'h100, 0, 1, 0, 0, 0, 1, 0};
    vecs[2] = '{32'h100, 0, 0, 1, 0, 1, 0, 0};
    vecs[3] = '{32'h114, 1, 0, 0, 1, 0, 0, 0};
    vecs[4] = '{32'h3fc, 0, 1, 0, 0, 0, 1, 0};
    vecs[5] = '{32'h000, 1, 1, 1, 0, 1, 0, 0};
    vecs[6] = '{32'hfffffffc, 1, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{32'h214, 0, 1, 1, 1, 1, 1, 0};

    rst = 1'b1; padv_decode = 0; padv_execute = 0; pipeline_flush = 0;
    op_bf = 0; op_bnf = 0; decode_pc = '0;
    execute_op_bf = 0; execute_op_bnf = 0; flag = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();

    // Reset table, nothing in execute: purely combinational checks.
    for (int v = 0; v < 8; v++) begin
      decode_pc = vecs[v].pc; op_bf = vecs[v].bf; op_bnf = vecs[v].bnf;
      execute_op_bf = vecs[v].ebf; execute_op_bnf = vecs[v].ebnf; flag = vecs[v].f;
      padv_execute = 1'b1;
      #2;
      check("reset_pred_vec", predicted_flag, vecs[v].exp_pred);
      check("reset_misp_vec", branch_mispredict, vecs[v].exp_misp);
    end
    @(posedge clk);
    #1;

    // Train 0x100 taken to saturation, then one not-taken.
    cyc(0, 1, 0, 0, 1, 0, 32'h100, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0, 32'h100, 1, 0, 1);
    cyc(0, 1, 1, 0, 1, 0, 32'h100, 1, 0, 1);
    cyc(0, 1, 1, 0, 1, 0, 32'h100, 1, 0, 1);
    cyc(0, 1, 1, 0, 0, 0, 32'h100, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 0, 32'h100, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 32'h000, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0);

    // Drive 0x200 to 00 and hold there, then a taken resolution mispredicts once.
    cyc(0, 1, 0, 0, 1, 0, 32'h200, 0, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 1, 0, 32'h200, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 32'h200, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 32'h000, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 1, 32'h200, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 32'h000, 0, 1, 0);

    // Index 5: update and read in the same cycle, 0x114/0x214/0x014 alias.
    cyc(0, 1, 0, 0, 1, 0, 32'h114, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0, 32'h214, 1, 0, 1);
    cyc(0, 1, 1, 0, 1, 0, 32'h214, 1, 0, 1);
    cyc(0, 1, 1, 0, 0, 0, 32'h014, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 32'h114, 0, 0, 0);

    // Flush beats capture; flush with branch in execute discards its update.
    cyc(0, 1, 0, 1, 1, 0, 32'h300, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 32'h000, 1, 0, 1);
    cyc(0, 1, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 32'h000, 1, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 32'h000, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 0);

    // Reset while an update is pending.
    cyc(0, 1, 0, 0, 1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h000, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h000, 1, 0, 1);

    // Randomised traffic over a few aliasing PCs.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hfffc) : pcs[$urandom_range(0, 5)];
      cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          $urandom_range(0, 9) == 0, 1'($urandom()), 1'($urandom()), rpc,
          1'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
